decimal_keypad_encoder: RTL

Registered, debounced successor to the combinational one-hot decimal-to-binary encoder. It samples an N_KEYS-wide key bus, synchronises and debounces it, and encodes the lowest pressed key index to binary. The code is presented on a valid/ready handshake, and the block then waits for a clean release before it accepts the next key. It sits between raw keypad/switch inputs and the control datapath.

---
 rtl/decimal_keypad_encoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/decimal_keypad_encoder.sv
// decimal_keypad_encoder
// Debounced key-bus encoder. The raw key vector is synchronised and debounced,
// then the lowest pressed key index is presented as a binary code on a
// valid/ready handshake. After the transfer the block waits for a clean,
// debounced release before it accepts another press.
//
// Optional build macro: DECIMAL_KEYPAD_MULTI_ERR_EN adds the multi_err output,
// flagging a code that came from a snapshot with more than one key pressed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key seen; waiting for any synchronised key bit
// DEBOUNCE | snapshot captured; counting identical samples
// HOLD     | code_out/code_valid presented, waiting for code_ready
// RELEASE  | code taken; counting consecutive all-zero samples
module decimal_keypad_encoder #(
  parameter int N_KEYS    = 10,
  parameter int CODE_W    = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  input  logic              code_ready,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  output logic              busy
`ifdef DECIMAL_KEYPAD_MULTI_ERR_EN
  ,
  output logic              multi_err
`endif
);

  // The counter never has to hold DB_CYCLES itself: reaching the last count
  // triggers the state change instead of another increment.
  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [N_KEYS-1:0]   sync1_q, sync1_d;
  logic [N_KEYS-1:0]   sync2_q, sync2_d;
  logic [N_KEYS-1:0]   snap_q, snap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [CODE_W-1:0]   snap_code;

  // Two-flop synchroniser for the asynchronous key levels.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
  end

  // Lowest set bit of the snapshot wins; scanning downwards lets it overwrite.
  always_comb begin
    snap_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (snap_q[i]) snap_code = CODE_W'(i);
    end
  end

  // Next-state, counter, snapshot and output-register logic.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (sync2_q != '0) begin
          snap_d  = sync2_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync2_q == '0) begin
          state_d = IDLE;
        end else if (sync2_q != snap_q) begin
          snap_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = snap_code;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (code_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (sync2_q != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= '0;
      sync2_q <= '0;
      snap_q  <= '0;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign code_out   = code_q;
  assign code_valid = valid_q;
  assign busy       = busy_q;

`ifdef DECIMAL_KEYPAD_MULTI_ERR_EN
  logic multi_q, multi_d;

  // The snapshot is frozen while the code is presented, so the flag can be
  // derived from it every cycle and tracks code_valid exactly.
  always_comb begin
    multi_d = valid_d && ((snap_d & (snap_d - N_KEYS'(1))) != '0);
  end

  // Multi-key flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) multi_q <= 1'b0;
    else     multi_q <= multi_d;
  end

  assign multi_err = multi_q;
`endif

endmodule
